// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, resolve-stage update and statistics signals of the branch predictor
interface branch_predictor_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_mispredict;
  logic             stats_clr;
  logic [CNT_W-1:0] lookup_count;
  logic [CNT_W-1:0] mispredict_count;
  modport master (
    output if_valid, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, stats_clr,
    input  pred_taken, pred_target, lookup_count, mispredict_count
  );
  modport slave (
    input  if_valid, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, stats_clr,
    output pred_taken, pred_target, lookup_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped tagged BTB with per-entry direction counters and saturating perf counters
module branch_predictor #(
  parameter int XLEN     = 64,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int MODE     = 2,
  parameter int CNT_W    = 32
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam bit EN = MODE != 0;
  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [CNT_W-1:0]    r_lookup;
  logic [CNT_W-1:0]    r_mispredict;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_uidx;
  logic [TAG_BITS-1:0] w_tag;
  logic [TAG_BITS-1:0] w_utag;
  logic                w_hit;
  logic                w_uhit;
  logic                w_write;
  logic [1:0]          w_ctr_nxt;
  logic                w_unused;
  always_comb begin
    w_idx     = bus.if_pc[IW+1:2];
    w_tag     = bus.if_pc[TAG_BITS+IW+1:IW+2];
    w_uidx    = bus.upd_pc[IW+1:2];
    w_utag    = bus.upd_pc[TAG_BITS+IW+1:IW+2];
    w_hit     = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    w_uhit    = r_valid[w_uidx] && r_tag[w_uidx] == w_utag;
    w_write   = EN && !reset && bus.upd_valid && (w_uhit || bus.upd_taken);
    // a miss only reaches here when taken, so it allocates with the scheme's initial strength
    w_ctr_nxt = !w_uhit ? (MODE == 1 ? 2'd3 : 2'd2) :
                MODE == 1 ? {2{bus.upd_taken}} :
                bus.upd_taken ? (r_ctr[w_uidx] == 2'd3 ? 2'd3 : r_ctr[w_uidx] + 2'd1) :
                (r_ctr[w_uidx] == 2'd0 ? 2'd0 : r_ctr[w_uidx] - 2'd1);
    bus.pred_taken       = EN && !reset && bus.if_valid && w_hit && r_ctr[w_idx][1];
    bus.pred_target      = (EN && !reset && w_hit) ? r_target[w_idx] : '0;
    bus.lookup_count     = r_lookup;
    bus.mispredict_count = r_mispredict;
    w_unused             = ^{bus.if_pc, bus.upd_pc};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'd0;
    end else if (w_write) begin
      r_valid[w_uidx] <= 1'b1;
      r_ctr[w_uidx]   <= w_ctr_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_write && bus.upd_taken) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= bus.upd_target;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || bus.stats_clr) begin
      r_lookup     <= '0;
      r_mispredict <= '0;
    end else begin
      if (bus.if_valid && !(&r_lookup)) r_lookup <= r_lookup + CNT_W'(1);
      if (bus.upd_valid && bus.upd_mispredict && !(&r_mispredict)) r_mispredict <= r_mispredict + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench driving MODE 2 / 1 / 0 predictors with shared stimulus
module tb_branch_predictor;
  typedef struct {string n; logic [63:0] v;} exp_t;
  exp_t sb[$];
  int vecs, errs;
  logic clk = 1'b0;
  logic reset, if_valid, upd_valid, upd_taken, upd_mispredict, stats_clr;
  logic [63:0] if_pc, upd_pc, upd_target;
  always #5 clk = ~clk;
  branch_predictor_if #(.CNT_W(4)) b2 ();
  branch_predictor_if b1 ();
  branch_predictor_if b0 ();
  assign {b2.if_valid, b2.if_pc, b2.upd_valid, b2.upd_pc, b2.upd_taken, b2.upd_target, b2.upd_mispredict, b2.stats_clr} =
         {if_valid, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, stats_clr};
  assign {b1.if_valid, b1.if_pc, b1.upd_valid, b1.upd_pc, b1.upd_taken, b1.upd_target, b1.upd_mispredict, b1.stats_clr} =
         {if_valid, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, stats_clr};
  assign {b0.if_valid, b0.if_pc, b0.upd_valid, b0.upd_pc, b0.upd_taken, b0.upd_target, b0.upd_mispredict, b0.stats_clr} =
         {if_valid, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, stats_clr};
  branch_predictor #(.MODE(2), .CNT_W(4)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  branch_predictor #(.MODE(1))            u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  branch_predictor #(.MODE(0))            u0 (.clk(clk), .reset(reset), .bus(b0.slave));

  task automatic want(input string n, input logic [63:0] v);
    sb.push_back('{n, v});
  endtask
  task automatic cyc;
    @(posedge clk); #1;
    if_valid = 1'b0; upd_valid = 1'b0; stats_clr = 1'b0;
  endtask
  task automatic look(input logic [63:0] pc);
    if_valid = 1'b1; if_pc = pc;
    @(negedge clk);
  endtask
  task automatic upd(input logic [63:0] pc, input logic t, input logic [63:0] tg);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tg;
    cyc();
  endtask

  task automatic test_reset;
    logic [63:0] o[$];
    exp_t e;
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    want("rst_pt", 0); want("rst_tgt", 0);
    look(64'h100);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target);
    cyc();
    want("rst_lookup2", 1); want("rst_lookup0", 1); want("rst_misp", 0);
    o.push_back(64'(b2.lookup_count)); o.push_back(64'(b0.lookup_count)); o.push_back(64'(b2.mispredict_count));
    foreach (o[i]) begin
      e = sb.pop_front(); vecs++;
      if (o[i] !== e.v) begin errs++; $display("FAIL %s: got %0h expected %0h", e.n, o[i], e.v); end
    end
  endtask

  task automatic test_train;
    logic [63:0] o[$];
    exp_t e;
    upd(64'h100, 1, 64'h80);
    want("t1_pt2", 1); want("t1_tgt2", 64'h80); want("t1_pt1", 1); want("t1_tgt1", 64'h80); want("t1_pt0", 0); want("t1_tgt0", 0);
    look(64'h100);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target); o.push_back(64'(b1.pred_taken));
    o.push_back(b1.pred_target); o.push_back(64'(b0.pred_taken)); o.push_back(b0.pred_target);
    cyc();
    upd(64'h100, 0, 64'h0);
    want("nt_pt2", 0); want("nt_tgt2", 64'h80); want("nt_pt1", 0); want("nt_pt0", 0);
    look(64'h100);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target); o.push_back(64'(b1.pred_taken)); o.push_back(64'(b0.pred_taken));
    cyc();
    upd(64'h100, 1, 64'h80);
    upd(64'h100, 1, 64'h80);
    upd(64'h100, 0, 64'h0);
    want("sat_pt2", 1); want("sat_pt1", 0); want("sat_pt0", 0);
    look(64'h100);
    o.push_back(64'(b2.pred_taken)); o.push_back(64'(b1.pred_taken)); o.push_back(64'(b0.pred_taken));
    cyc();
    foreach (o[i]) begin
      e = sb.pop_front(); vecs++;
      if (o[i] !== e.v) begin errs++; $display("FAIL %s: got %0h expected %0h", e.n, o[i], e.v); end
    end
  endtask

  task automatic test_alias;
    logic [63:0] o[$];
    exp_t e;
    upd(64'h200, 0, 64'h0);
    want("alias_keep_pt", 1); want("alias_keep_tgt", 64'h80);
    look(64'h100);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target);
    cyc();
    upd(64'h200, 1, 64'h40);
    want("alias_old_pt", 0); want("alias_old_tgt", 0);
    look(64'h100);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target);
    cyc();
    want("alias_new_pt2", 1); want("alias_new_tgt2", 64'h40); want("alias_new_pt1", 1); want("alias_new_pt0", 0);
    look(64'h200);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target); o.push_back(64'(b1.pred_taken)); o.push_back(64'(b0.pred_taken));
    cyc();
    foreach (o[i]) begin
      e = sb.pop_front(); vecs++;
      if (o[i] !== e.v) begin errs++; $display("FAIL %s: got %0h expected %0h", e.n, o[i], e.v); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] o[$];
    exp_t e;
    upd_valid = 1'b1; upd_pc = 64'h104; upd_taken = 1'b1; upd_target = 64'h300;
    want("rbw_pt", 0); want("rbw_tgt", 0);
    look(64'h104);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target);
    cyc();
    want("rbw_next_pt", 1); want("rbw_next_tgt", 64'h300);
    look(64'h104);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target);
    cyc();
    foreach (o[i]) begin
      e = sb.pop_front(); vecs++;
      if (o[i] !== e.v) begin errs++; $display("FAIL %s: got %0h expected %0h", e.n, o[i], e.v); end
    end
  endtask

  task automatic test_counters;
    logic [63:0] o[$];
    exp_t e;
    stats_clr = 1'b1;
    cyc();
    repeat (20) begin
      upd_valid = 1'b1; upd_mispredict = 1'b1; upd_pc = 64'h1000; upd_taken = 1'b0;
      cyc();
    end
    upd_mispredict = 1'b0;
    want("misp_sat4", 15); want("misp_32", 20); want("lookup_clr", 0);
    o.push_back(64'(b2.mispredict_count)); o.push_back(64'(b1.mispredict_count)); o.push_back(64'(b1.lookup_count));
    want("entry_kept", 1);
    look(64'h200);
    o.push_back(64'(b2.pred_taken));
    stats_clr = 1'b1; upd_valid = 1'b1; upd_mispredict = 1'b1;
    cyc();
    upd_mispredict = 1'b0;
    want("clr_win_misp2", 0); want("clr_win_misp1", 0); want("clr_win_look", 0);
    o.push_back(64'(b2.mispredict_count)); o.push_back(64'(b1.mispredict_count)); o.push_back(64'(b2.lookup_count));
    foreach (o[i]) begin
      e = sb.pop_front(); vecs++;
      if (o[i] !== e.v) begin errs++; $display("FAIL %s: got %0h expected %0h", e.n, o[i], e.v); end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] o[$];
    exp_t e;
    want("pre_rst_pt", 1);
    look(64'h200);
    o.push_back(64'(b2.pred_taken));
    cyc();
    upd_valid = 1'b1; upd_pc = 64'h108; upd_taken = 1'b1; upd_target = 64'h500; upd_mispredict = 1'b1;
    reset = 1'b1;
    want("in_rst_pt2", 0); want("in_rst_tgt2", 0); want("in_rst_pt1", 0);
    look(64'h200);
    o.push_back(64'(b2.pred_taken)); o.push_back(b2.pred_target); o.push_back(64'(b1.pred_taken));
    cyc();
    reset = 1'b0; upd_mispredict = 1'b0;
    want("post_rst_look2", 0); want("post_rst_misp2", 0); want("post_rst_look1", 0); want("post_rst_misp1", 0);
    o.push_back(64'(b2.lookup_count)); o.push_back(64'(b2.mispredict_count));
    o.push_back(64'(b1.lookup_count)); o.push_back(64'(b1.mispredict_count));
    want("post_rst_200", 0); want("post_rst_108", 0); want("post_rst_104", 0);
    look(64'h200); o.push_back(64'(b2.pred_taken)); cyc();
    look(64'h108); o.push_back(64'(b2.pred_taken)); cyc();
    look(64'h104); o.push_back(64'(b2.pred_taken)); cyc();
    foreach (o[i]) begin
      e = sb.pop_front(); vecs++;
      if (o[i] !== e.v) begin errs++; $display("FAIL %s: got %0h expected %0h", e.n, o[i], e.v); end
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    reset = 1'b1; if_valid = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; stats_clr = 1'b0;
    test_reset();
    test_train();
    test_alias();
    test_back_to_back();
    test_counters();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
